// File: rtl/iterative_divider.sv
// RV32M divide/remainder unit (DIV, DIVU, REM, REMU): radix-2 restoring division,
// one quotient bit per clock, with result and destination index presented for write-back.
module iterative_divider #(
   parameter int XLEN   = 32,
   parameter int ADDR_W = 5
) (
   input  logic              clk,
   input  logic              areset,
   input  logic              start,
   input  logic [1:0]        op,
   input  logic [XLEN-1:0]   dividend,
   input  logic [XLEN-1:0]   divisor,
   input  logic [ADDR_W-1:0] rd_in,
   input  logic              flush,
   output logic              ready,
   output logic              busy,
   output logic              done,
   output logic [XLEN-1:0]   result,
   output logic [ADDR_W-1:0] rd_out,
   output logic              we
);

   localparam int                CNT_W   = $clog2(XLEN);
   localparam logic [CNT_W-1:0]  LAST    = CNT_W'(XLEN - 1);
   localparam logic [XLEN-1:0]   MIN_INT = {1'b1, {(XLEN-1){1'b0}}};

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   state_t            state;
   logic [CNT_W-1:0]  count;
   logic [XLEN-1:0]   q;
   logic [XLEN-1:0]   rem;
   logic [XLEN-1:0]   dvsr;
   logic              neg_q;
   logic              neg_r;
   logic              is_rem;
   logic [ADDR_W-1:0] rd_lat;

   // Accept-time decode: magnitudes, result signs and the two shortcut cases.
   logic            is_signed;
   logic            a_neg;
   logic            b_neg;
   logic            div_zero;
   logic            overflow;
   logic [XLEN-1:0] a_abs;
   logic [XLEN-1:0] b_abs;
   logic [XLEN-1:0] special_result;

   // NOTE: every always_comb output gets a value on every path, so no latch can be inferred.
   always_comb begin
      is_signed      = ~op[0];
      a_neg          = is_signed & dividend[XLEN-1];
      b_neg          = is_signed & divisor[XLEN-1];
      a_abs          = a_neg ? -dividend : dividend;
      b_abs          = b_neg ? -divisor : divisor;
      div_zero       = (divisor == '0);
      overflow       = is_signed && (dividend == MIN_INT) && (divisor == '1);
      special_result = '0;
      if (op[1])
         special_result = div_zero ? dividend : '0;
      else
         special_result = div_zero ? '1 : MIN_INT;
   end

   // One restoring step; the compare needs the bit shifted out of rem.
   logic [XLEN:0]   rem_shift;
   logic            ge;
   logic [XLEN-1:0] rem_sub;
   logic [XLEN-1:0] rem_next;
   logic [XLEN-1:0] q_next;
   logic [XLEN-1:0] quo_fin;
   logic [XLEN-1:0] rem_fin;

   always_comb begin
      rem_shift = {rem, q[XLEN-1]};
      ge        = (rem_shift >= {1'b0, dvsr});
      rem_sub   = rem_shift[XLEN-1:0] - dvsr;
      rem_next  = ge ? rem_sub : rem_shift[XLEN-1:0];
      q_next    = {q[XLEN-2:0], ge};
      quo_fin   = neg_q ? -q_next : q_next;
      rem_fin   = neg_r ? -rem_next : rem_next;
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (areset) begin
         state  <= IDLE;
         count  <= '0;
         q      <= '0;
         rem    <= '0;
         dvsr   <= '0;
         neg_q  <= 1'b0;
         neg_r  <= 1'b0;
         is_rem <= 1'b0;
         rd_lat <= '0;
         done   <= 1'b0;
         result <= '0;
         rd_out <= '0;
      end else begin
         case (state)
            IDLE: begin
               done <= 1'b0;
               if (start) begin
                  if (div_zero || overflow) begin
                     result <= special_result;
                     rd_out <= rd_in;
                     done   <= 1'b1;
                     state  <= DONE;
                  end else begin
                     q      <= a_abs;
                     rem    <= '0;
                     dvsr   <= b_abs;
                     neg_q  <= a_neg ^ b_neg;
                     neg_r  <= a_neg;
                     is_rem <= op[1];
                     rd_lat <= rd_in;
                     count  <= '0;
                     state  <= CALC;
                  end
               end
            end
            CALC: begin
               if (flush) begin
                  state <= IDLE;
               end else begin
                  q     <= q_next;
                  rem   <= rem_next;
                  count <= count + 1'b1;
                  if (count == LAST) begin
                     result <= is_rem ? rem_fin : quo_fin;
                     rd_out <= rd_lat;
                     done   <= 1'b1;
                     state  <= DONE;
                  end
               end
            end
            DONE: begin
               done  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               done  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

   assign ready = (state == IDLE);
   assign busy  = (state != IDLE);
   assign we    = done;

endmodule

// File: tb/tb_iterative_divider.sv
// Self-checking bench for iterative_divider: directed vector table, multi-cycle corner
// sequences (ignored start, flush, mid-operation reset) and randomized ops against an arithmetic model.
module tb_iterative_divider;

   logic        clk = 1'b0;
   logic        areset;
   logic        start;
   logic [1:0]  op;
   logic [31:0] dividend;
   logic [31:0] divisor;
   logic [4:0]  rd_in;
   logic        flush;
   logic        ready;
   logic        busy;
   logic        done;
   logic [31:0] result;
   logic [4:0]  rd_out;
   logic        we;

   iterative_divider #(.XLEN(32), .ADDR_W(5)) dut (
      .clk      (clk),
      .areset   (areset),
      .start    (start),
      .op       (op),
      .dividend (dividend),
      .divisor  (divisor),
      .rd_in    (rd_in),
      .flush    (flush),
      .ready    (ready),
      .busy     (busy),
      .done     (done),
      .result   (result),
      .rd_out   (rd_out),
      .we       (we)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   typedef struct {
      string       name;
      logic [1:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [4:0]  rd;
      logic [31:0] exp;
      int          lat;
   } vec_t;

   vec_t vecs[11];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
   endtask

   // Sample 1 ns after the rising edge; inputs are also driven there.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Reference: plain RV32M arithmetic on 64-bit integers.
   function automatic logic [31:0] ref_result(input logic [1:0] o, input logic [31:0] a,
                                               input logic [31:0] b);
      longint sa, sb, ua, ub, r;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ua = longint'({32'h0, a});
      ub = longint'({32'h0, b});
      if (b == 32'h0) return o[1] ? a : 32'hFFFF_FFFF;
      case (o)
         2'd0:    r = sa / sb;
         2'd1:    r = ua / ub;
         2'd2:    r = sa % sb;
         default: r = ua % ub;
      endcase
      return r[31:0];
   endfunction

   function automatic int ref_lat(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
      if (b == 32'h0) return 1;
      if (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
      return 33;
   endfunction

   task automatic wait_ready(input string name);
      for (int i = 0; i < 100 && !ready; i++) step();
      check({name, " ready"}, 32'(ready), 32'd1);
   endtask

   // Issue one op, scramble inputs after accept, time the done pulse and check the write-back.
   task automatic run_op(input string name, input logic [1:0] o, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] rd,
                         input logic [31:0] exp, input int exp_lat);
      int lat;
      wait_ready(name);
      op = o; dividend = a; divisor = b; rd_in = rd; start = 1'b1;
      step();
      start    = 1'b0;
      op       = 2'($urandom);
      dividend = $urandom;
      divisor  = $urandom;
      rd_in    = 5'($urandom);
      lat = 1;
      while (!done && lat < 100) begin
         step();
         lat++;
      end
      check({name, " latency"}, 32'(lat), 32'(exp_lat));
      check({name, " result"}, result, exp);
      check({name, " rd_out"}, 32'(rd_out), 32'(rd));
      check({name, " we"}, 32'(we), 32'd1);
      step();
      check({name, " done pulse"}, 32'(done), 32'd0);
   endtask

   // Accept DIV 100/7 and return right after the accept edge (cycle T+1).
   task automatic accept_100_7(input string name, input logic [4:0] rd);
      wait_ready(name);
      op = 2'd0; dividend = 32'd100; divisor = 32'd7; rd_in = rd; start = 1'b1;
      step();
      start = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int done_cnt, done_k, first_ready;
      logic [31:0] res_at_done;

      vecs[0]  = '{"div_100_7",   2'd0, 32'd100,       32'd7,         5'd5,  32'd14,        33};
      vecs[1]  = '{"div_m7_2",    2'd0, 32'hFFFF_FFF9, 32'd2,         5'd1,  32'hFFFF_FFFD, 33};
      vecs[2]  = '{"rem_m7_2",    2'd2, 32'hFFFF_FFF9, 32'd2,         5'd2,  32'hFFFF_FFFF, 33};
      vecs[3]  = '{"divu_max_2",  2'd1, 32'hFFFF_FFFF, 32'd2,         5'd3,  32'h7FFF_FFFF, 33};
      vecs[4]  = '{"divu_5_0",    2'd1, 32'd5,         32'd0,         5'd4,  32'hFFFF_FFFF, 1};
      vecs[5]  = '{"remu_5_0",    2'd3, 32'd5,         32'd0,         5'd6,  32'd5,         1};
      vecs[6]  = '{"div_ovf",     2'd0, 32'h8000_0000, 32'hFFFF_FFFF, 5'd7,  32'h8000_0000, 1};
      vecs[7]  = '{"rem_ovf",     2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 5'd8,  32'd0,         1};
      vecs[8]  = '{"rem_min_0",   2'd2, 32'h8000_0000, 32'd0,         5'd9,  32'h8000_0000, 1};
      vecs[9]  = '{"div_7_0",     2'd0, 32'd7,         32'd0,         5'd10, 32'hFFFF_FFFF, 1};
      vecs[10] = '{"remu_100_7",  2'd3, 32'd100,       32'd7,         5'd31, 32'd2,         33};

      areset = 1'b1; start = 1'b0; flush = 1'b0;
      op = 2'd0; dividend = '0; divisor = '0; rd_in = '0;
      repeat (3) step();
      check("reset ready",  32'(ready),  32'd1);
      check("reset busy",   32'(busy),   32'd0);
      check("reset done",   32'(done),   32'd0);
      check("reset we",     32'(we),     32'd0);
      check("reset result", result,      32'd0);
      check("reset rd_out", 32'(rd_out), 32'd0);
      areset = 1'b0;
      step();

      for (int i = 0; i < 11; i++)
         run_op(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].rd, vecs[i].exp, vecs[i].lat);

      // start while busy is dropped; exactly one done with the original operands.
      accept_100_7("ignored_start", 5'd5);
      done_cnt = 0; done_k = 0; first_ready = 0; res_at_done = '0;
      for (int k = 1; k <= 40; k++) begin
         if (done) begin
            done_cnt++;
            done_k = k;
            res_at_done = result;
         end
         if (ready && first_ready == 0) first_ready = k;
         if (k == 10) begin
            start = 1'b1; op = 2'd1; dividend = 32'd9; divisor = 32'd3; rd_in = 5'd7;
         end else begin
            start = 1'b0;
         end
         step();
      end
      check("ignored_start done count",  32'(done_cnt),    32'd1);
      check("ignored_start done cycle",  32'(done_k),      32'd33);
      check("ignored_start result",      res_at_done,      32'd14);
      check("ignored_start ready cycle", 32'(first_ready), 32'd34);

      // flush mid-CALC: no done, idle next cycle, old result held.
      accept_100_7("flush", 5'd12);
      done_cnt = 0;
      for (int k = 1; k <= 45; k++) begin
         if (done) done_cnt++;
         if (k == 13) begin
            check("flush ready at T+13", 32'(ready), 32'd1);
            check("flush busy at T+13",  32'(busy),  32'd0);
         end
         flush = (k == 12);
         step();
      end
      flush = 1'b0;
      check("flush done count", 32'(done_cnt), 32'd0);
      check("flush result held", result, 32'd14);
      run_op("divu_9_3_after_flush", 2'd1, 32'd9, 32'd3, 5'd3, 32'd3, 33);

      // reset mid-CALC: outputs return to reset values and the op never completes.
      accept_100_7("areset", 5'd9);
      done_cnt = 0;
      for (int k = 1; k <= 45; k++) begin
         if (done) done_cnt++;
         if (k == 21) begin
            check("areset ready",  32'(ready),  32'd1);
            check("areset busy",   32'(busy),   32'd0);
            check("areset done",   32'(done),   32'd0);
            check("areset we",     32'(we),     32'd0);
            check("areset result", result,      32'd0);
            check("areset rd_out", 32'(rd_out), 32'd0);
         end
         areset = (k == 20);
         step();
      end
      areset = 1'b0;
      check("areset done count", 32'(done_cnt), 32'd0);

      for (int i = 0; i < 40; i++) begin
         logic [1:0]  o;
         logic [31:0] a, b;
         logic [4:0]  rd;
         int          sel;
         o   = 2'($urandom);
         a   = $urandom;
         b   = $urandom;
         rd  = 5'($urandom);
         sel = int'($urandom_range(0, 9));
         case (sel)
            0:       b = 32'd0;
            1:       begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
            2:       b = $urandom_range(1, 15);
            3:       b = -($urandom_range(1, 15));
            4:       a = $urandom_range(0, 20);
            default: ;
         endcase
         run_op($sformatf("rand%0d", i), o, a, b, rd, ref_result(o, a, b), ref_lat(o, a, b));
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
